// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and constants for the sequential multiplier.
//   state_e        controller state (IDLE, RUN, DONE)
//   ST_*           2-bit state encodings
//   DEFAULT_WIDTH  default operand width
package seq_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: start/done handshake and operand/result bundle.
//   start, a, b            driven by the requester (master)
//   busy, done, product    driven by the multiplier (slave)
interface seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/rca_adder.sv
// rca_adder: WIDTH-bit ripple-carry adder built from full-adder cells.
//   a, b   addends
//   cin    carry in (set to 1 with an inverted operand to subtract)
//   sum    WIDTH-bit sum
//   cout   carry out of the top cell
module rca_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// seq_mult: sequential shift-and-add multiplier, one adder pass per clock.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   seq_mult_if.slave: start/a/b in; busy/done/product out
// Macro SEQ_MULT_SIGNED_EN: treat a, b and product as two's complement
// (arithmetic partial-sum shift, subtract on the final iteration).
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic     clk,
  input logic     rst,
  seq_mult_if.slave bus
);

  state_e r_state, w_state_d;

  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0] w_addend;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mplr_nxt;

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  always_comb begin
    w_addend = r_mplr[0] ? r_mcand : '0;
    w_cin    = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    // The multiplier's MSB carries negative weight: subtract on the last pass.
    if (w_last && r_mplr[0]) begin
      w_addend = ~r_mcand;
      w_cin    = 1'b1;
    end
`endif
  end

  rca_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_acc),
    .b    (w_addend),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

`ifdef SEQ_MULT_SIGNED_EN
  // Bit WIDTH of the sign-extended sum, so 0 - (-2^(W-1)) stays positive.
  assign w_msb = r_acc[WIDTH-1] ^ w_addend[WIDTH-1] ^ w_cout;
`else
  assign w_msb = w_cout;
`endif

  assign w_acc_nxt  = {w_msb, w_sum[WIDTH-1:1]};
  assign w_mplr_nxt = {w_sum[0], r_mplr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_mcand <= bus.a;
            r_mplr  <= bus.b;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        StRun: begin
          r_acc   <= w_acc_nxt;
          r_mplr  <= w_mplr_nxt;
          r_count <= r_count + 1'b1;
          if (w_last) r_product <= {w_acc_nxt, w_mplr_nxt};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state == StRun);
  assign bus.done    = (r_state == StDone);
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed bench for seq_mult (WIDTH=8) with hand-computed products.
module tb_seq_mult;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: busy for W cycles after the accepting edge, then one done cycle.
  task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib,
                          input logic [15:0] exp, input string tag);
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~ia;
    bus.b     = ~ib;
    busy_cnt  = 0;
    for (int i = 0; i < W; i++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
    check({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    check({tag, "_busy_low"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_product"}, 64'(bus.product), 64'(exp));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    check({tag, "_hold"}, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    int done_cnt;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_mult(8'd13, 8'd11, 16'h008F, "m13x11");
`ifdef SEQ_MULT_SIGNED_EN
    run_mult(8'hFF, 8'hFF, 16'h0001, "m_neg1xneg1");
`else
    run_mult(8'hFF, 8'hFF, 16'hFE01, "m255x255");
`endif
    run_mult(8'd0, 8'd200, 16'h0000, "m0x200");

    // Stray start during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd7;
    bus.b     = 8'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd2;
    bus.b     = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", {63'd0, bus.busy}, 64'd1);
    check("ign_product_run", 64'(bus.product), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("ign_done_count", 64'(done_cnt), 64'd1);
    check("ign_product", 64'(bus.product), 64'd42);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 8'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_mult(8'd3, 8'd3, 16'd9, "m3x3");

    // Start held high: a result every W+2 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd5;
    bus.b     = 8'd5;
    @(posedge clk);
    for (int rep = 0; rep < 3; rep++) begin
      #1;
      check("b2b_busy", {63'd0, bus.busy}, 64'd1);
      repeat (W) @(posedge clk);
      #1;
      check("b2b_done", {63'd0, bus.done}, 64'd1);
      check("b2b_product", 64'(bus.product), 64'd25);
      @(posedge clk);
      #1;
      check("b2b_idle", {62'd0, bus.busy, bus.done}, 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("b2b_final_product", 64'(bus.product), 64'd25);

`ifdef SEQ_MULT_SIGNED_EN
    run_mult(8'hFD, 8'd5, 16'hFFF1, "s_neg3x5");
    run_mult(8'h80, 8'h80, 16'h4000, "s_neg128xneg128");
    run_mult(8'd127, 8'hFF, 16'hFF81, "s_127xneg1");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
